// File: rtl/mat_pkg.sv
// mat_pkg: shared FSM state type and default element width / matrix size for the mat_seq block
package mat_pkg;
  localparam int DW = 32;
  localparam int N = 9;
  typedef enum logic [1:0] {LOAD, KICK, WAIT, DRAIN} state_t;
endpackage

// File: rtl/mat_if.sv
// mat_if: in_* operand load, core_* start/done/operands/result, out_* result drain, busy/err status; master = environment, slave = mat_seq
interface mat_if #(parameter int DW = mat_pkg::DW, parameter int N = mat_pkg::N);
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic core_start;
  logic [N*DW-1:0] core_a;
  logic [N*DW-1:0] core_b;
  logic core_done;
  logic [N*DW-1:0] core_c;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_data;
  logic out_last;
  logic busy;
  logic err;
  modport master (
    output in_valid, in_a, in_b, core_done, core_c, out_ready,
    input in_ready, core_start, core_a, core_b, out_valid, out_data, out_last, busy, err
  );
  modport slave (
    input in_valid, in_a, in_b, core_done, core_c, out_ready,
    output in_ready, core_start, core_a, core_b, out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/mat_buf.sv
// mat_buf: A/B serial write at i_idx (i_we) with packed parallel read o_a/o_b; C parallel write (i_cwe, i_c) with serial read o_c at i_idx
module mat_buf #(
  parameter int DW = mat_pkg::DW,
  parameter int N = mat_pkg::N
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [3:0]      i_idx,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic [N*DW-1:0] o_a,
  output logic [N*DW-1:0] o_b,
  input  logic            i_cwe,
  input  logic [N*DW-1:0] i_c,
  output logic [DW-1:0]   o_c
);
  logic [N-1:0][DW-1:0] r_a, r_b, r_c;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else begin
      if (i_we) begin
        r_a[i_idx] <= i_a;
        r_b[i_idx] <= i_b;
      end
      if (i_cwe) r_c <= i_c;
    end
  assign o_a = r_a;
  assign o_b = r_b;
  assign o_c = r_c[i_idx];
endmodule

// File: rtl/mat_seq.sv
// mat_seq: loads N operand pairs, kicks the element-wise core, waits (with timeout -> sticky err) and drains N results; clk, async active-high reset, mat_if.slave m
module mat_seq #(
  parameter int DW = 32,
  parameter int N = 9,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  mat_if.slave m
);
  import mat_pkg::*;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [3:0] LAST = 4'(N - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  state_t r_state, w_next;
  logic [3:0] r_idx, w_idx, w_inc;
  logic [TW-1:0] r_timer, w_timer;
  logic r_err, w_to, w_we, w_cwe, w_wrap;
  logic [DW-1:0] w_c;
  mat_buf #(.DW(DW), .N(N)) u_buf (
    .clk(clk),
    .reset(reset),
    .i_we(w_we),
    .i_idx(r_idx),
    .i_a(m.in_a),
    .i_b(m.in_b),
    .o_a(m.core_a),
    .o_b(m.core_b),
    .i_cwe(w_cwe),
    .i_c(m.core_c),
    .o_c(w_c)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= LOAD;
      r_idx <= '0;
      r_timer <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx <= w_idx;
      r_timer <= w_timer;
      r_err <= r_err | w_to;
    end
  always_comb begin
    w_next = r_state;
    w_idx = r_idx;
    w_timer = r_timer;
    w_to = 1'b0;
    w_wrap = r_idx == LAST;
    w_inc = w_wrap ? 4'd0 : r_idx + 4'd1;
    w_we = r_state == LOAD && m.in_valid;
    w_cwe = r_state == WAIT && m.core_done;
    m.in_ready = r_state == LOAD;
    m.core_start = r_state == KICK;
    m.out_valid = r_state == DRAIN;
    m.out_data = w_c;
    m.out_last = r_state == DRAIN && w_wrap;
    m.busy = !(r_state == LOAD && r_idx == '0);
    m.err = r_err;
    unique case (r_state)
      LOAD: if (m.in_valid) begin
        w_idx = w_inc;
        w_next = w_wrap ? KICK : LOAD;
      end
      KICK: begin
        w_timer = '0;
        w_next = WAIT;
      end
      WAIT: if (m.core_done) w_next = DRAIN;
        else if (r_timer == TMAX) begin
          w_to = 1'b1;
          w_idx = '0;
          w_next = LOAD;
        end else w_timer = r_timer + TW'(1);
      DRAIN: if (m.out_ready) begin
        w_idx = w_inc;
        w_next = w_wrap ? LOAD : DRAIN;
      end
      default: w_next = LOAD;
    endcase
  end
endmodule

// File: tb/tb_mat_seq.sv
// tb_mat_seq: directed scoreboard bench for mat_seq with a behavioural adder core
module tb_mat_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mat_if #(.DW(32), .N(9)) bus ();
  mat_seq #(.DW(32), .N(9), .TIMEOUT(64)) dut (.clk(clk), .reset(reset), .m(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [287:0] c_res = '0;
  int cnt = 0;
  int core_lat = 11;
  bit core_en = 1'b1;
  logic model_done = 1'b0;
  logic spur_done = 1'b0;
  assign bus.core_done = model_done | spur_done;
  assign bus.core_c = spur_done ? {9{32'hDEADBEEF}} : c_res;
  always @(negedge clk) begin
    model_done = 1'b0;
    if (reset) cnt = 0;
    else if (bus.core_start && core_en) begin
      cnt = core_lat;
      for (int k = 0; k < 9; k++) c_res[k*32 +: 32] = bus.core_a[k*32 +: 32] + bus.core_b[k*32 +: 32];
    end else if (cnt > 0) begin
      cnt--;
      model_done = cnt == 0;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int ab, input int as, input int bb, input int bs, input bit gap);
    for (int i = 0; i < 9; i++) begin
      if (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("no_early_start", bus.core_start, 0);
      end
      @(negedge clk);
      chk("in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_a = ab + as * i;
      bus.in_b = bb + bs * i;
      exp_q.push_back(32'(ab + as * i + bb + bs * i));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("core_start", bus.core_start, 1);
  endtask
  task automatic drain(input int stall_at, input int stall_len, input int abort_at, input int spur_at);
    int k = 0;
    int st = 0;
    int budget = 300;
    bit sp = 1'b0;
    while (k < abort_at && budget > 0) begin
      @(negedge clk);
      budget--;
      spur_done = 1'b0;
      if (k == spur_at && !sp && bus.out_valid) begin
        sp = 1'b1;
        spur_done = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        chk("no_in_drain", bus.in_ready, 0);
      end else if (k == stall_at && st < stall_len && bus.out_valid) begin
        st++;
        bus.out_ready = 1'b0;
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, exp_q[0]);
      end else begin
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        if (bus.out_valid) begin
          chk("data", bus.out_data, exp_q.pop_front());
          chk("last", bus.out_last, k == 8);
          k++;
        end
      end
    end
    chk("drain_count", k, abort_at);
    if (abort_at == 9) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_busy", bus.busy, 0);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_a", bus.core_a[63:0], 0);
    load(1, 1, 10, 10, 0);
    @(negedge clk);
    chk("start_one_cycle", bus.core_start, 0);
    chk("busy_wait", bus.busy, 1);
    repeat (10) @(negedge clk);
    chk("valid_before_done", bus.out_valid, 0);
    @(negedge clk);
    chk("valid_after_done", bus.out_valid, 1);
    drain(-1, 0, 9, -1);
    chk("err_basic", bus.err, 0);
    load(1, 1, 10, 10, 1);
    chk("core_a4", bus.core_a[4*32 +: 32], 5);
    chk("core_b8", bus.core_b[8*32 +: 32], 90);
    drain(-1, 0, 9, -1);
    load(3, 2, 1, 1, 0);
    drain(3, 5, 9, -1);
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spur_load_busy", bus.busy, 0);
    chk("spur_load_ready", bus.in_ready, 1);
    chk("spur_load_valid", bus.out_valid, 0);
    load(2, 7, 9, 3, 0);
    drain(-1, 0, 9, 2);
    core_en = 1'b0;
    load(100, 3, 7, 5, 0);
    repeat (64) @(negedge clk);
    chk("to_err_pre", bus.err, 0);
    chk("to_busy_pre", bus.busy, 1);
    @(negedge clk);
    chk("to_err", bus.err, 1);
    chk("to_busy", bus.busy, 0);
    chk("to_in_ready", bus.in_ready, 1);
    exp_q.delete();
    core_en = 1'b1;
    load(100, 3, 7, 5, 0);
    drain(-1, 0, 9, -1);
    chk("err_sticky", bus.err, 1);
    load(1, 0, 1, 0, 0);
    drain(-1, 0, 4, -1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("abort_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", bus.out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_err", bus.err, 0);
    chk("post_rst_valid", bus.out_valid, 0);
    exp_q.delete();
    load(1, 0, 1, 0, 0);
    drain(-1, 0, 9, -1);
    core_lat = 64;
    load(5, 1, 5, 1, 0);
    drain(-1, 0, 9, -1);
    chk("coincident_err", bus.err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
